// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB forwarding, ALU operand
// selection and load-use bubble insertion.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        id_valid,
  input  logic        id_regwrite,
  input  logic        id_memread,
  input  logic        id_memwrite,
  input  logic [4:0]  id_aluoper,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [4:0]  id_shamt,
  input  logic [15:0] id_imm,
  input  logic        exmem_regwrite,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_result,
  input  logic        memwb_regwrite,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_data,
  output logic [31:0] ex_adat,
  output logic [31:0] ex_bdat,
  output logic [4:0]  ex_aluoper,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_rd,
  output logic        ex_valid,
  output logic        ex_regwrite,
  output logic        ex_memread,
  output logic        ex_memwrite,
  output logic        load_use_stall
);

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned IW = 16;

  typedef struct packed {
    logic          valid;
    logic          regwrite;
    logic          memread;
    logic          memwrite;
    logic [RW-1:0] aluoper;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] rd;
    logic [RW-1:0] shamt;
    logic [IW-1:0] imm;
  } ex_fields_t;

  ex_fields_t    ex_q;
  ex_fields_t    ex_d;
  logic [DW-1:0] fwd_a;
  logic [DW-1:0] fwd_b;

  // Load in EX whose destination is read by the instruction in ID.
  always_comb begin
    load_use_stall = id_valid & ex_q.valid & ex_q.memread & (ex_q.rd != '0) &
                     ((ex_q.rd == id_rs) | (ex_q.rd == id_rt));
  end

  // Next-state selection: flush, then hold, then load-use bubble, then load.
  always_comb begin
    ex_d = ex_q;
    if (flush_i) begin
      ex_d = '0;
    end else if (stall_i) begin
      ex_d = ex_q;
    end else if (load_use_stall) begin
      ex_d = '0;
    end else begin
      ex_d.valid    = id_valid;
      ex_d.regwrite = id_regwrite;
      ex_d.memread  = id_memread;
      ex_d.memwrite = id_memwrite;
      ex_d.aluoper  = id_aluoper;
      ex_d.rs_data  = id_rs_data;
      ex_d.rt_data  = id_rt_data;
      ex_d.rs       = id_rs;
      ex_d.rt       = id_rt;
      ex_d.rd       = id_rd;
      ex_d.shamt    = id_shamt;
      ex_d.imm      = id_imm;
    end
  end

  // Stage register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  // Forwarding for rs and rt; EX/MEM wins over MEM/WB, register 0 never forwards.
  always_comb begin
    fwd_a = ex_q.rs_data;
    if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == ex_q.rs)) begin
      fwd_a = exmem_result;
    end else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == ex_q.rs)) begin
      fwd_a = memwb_data;
    end
    fwd_b = ex_q.rt_data;
    if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == ex_q.rt)) begin
      fwd_b = exmem_result;
    end else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == ex_q.rt)) begin
      fwd_b = memwb_data;
    end
  end

  // ALU operand select by operation code.
  always_comb begin
    ex_adat = fwd_a;
    ex_bdat = fwd_b;
    case (ex_q.aluoper)
      5'b00011, 5'b00100, 5'b00101: ex_adat = DW'(ex_q.shamt);
      5'b01100, 5'b01101, 5'b01111: ex_adat = DW'(fwd_a[RW-1:0]);
      5'b10000, 5'b10011, 5'b10100: ex_bdat = DW'($signed(ex_q.imm));
      5'b10001:                     ex_bdat = DW'(ex_q.imm);
      5'b10010: begin
        ex_adat = '0;
        ex_bdat = DW'(ex_q.imm);
      end
      default: begin
        ex_adat = fwd_a;
        ex_bdat = fwd_b;
      end
    endcase
  end

  assign ex_store_data = fwd_b;
  assign ex_aluoper    = ex_q.aluoper;
  assign ex_rd         = ex_q.rd;
  assign ex_valid      = ex_q.valid;
  assign ex_regwrite   = ex_q.regwrite;
  assign ex_memread    = ex_q.memread;
  assign ex_memwrite   = ex_q.memwrite;

endmodule
